rs_syndrome_calc: RTL
=====================

Name: rs_syndrome_calc

Overview:
- Decoder-side front end for the RS(255,239) datapath over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Consumes one received symbol per accepted cycle and accumulates all NPAR syndromes in parallel, using Horner's rule with gf256_const_mult instances (A = alpha^(FCR+j)).
- Presents the syndrome vector and a nonzero flag once per 255-symbol codeword.
- Feeds the downstream key-equation solver.

Parameters:
- NPAR, 16, number of parity symbols and syndromes (S_0..S_{NPAR-1}).
- FCR, 0, first consecutive root exponent; S_j is evaluated at alpha^(FCR+j). Must match the encoder generator polynomial.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  received symbol, highest-degree coefficient (r_254) first.
- din_valid  input  1  din is valid this cycle.
- din_sop  input  1  qualifies din as the first symbol of a codeword; ignored unless din_valid=1.
- synd  output  8*NPAR  syndrome vector; S_j occupies bits [8j+7:8j].
- synd_valid  output  1  one-cycle pulse; synd holds a complete codeword result.
- synd_nz  output  1  OR of all S_j; meaningful while synd_valid=1, held until the next result.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, rst_n=0): accumulators, symbol counter, synd, synd_valid, synd_nz and frame_err all go to 0. State goes to IDLE.
- Release of reset is synchronous-safe: the next accepted symbol must carry din_sop.

States:
- IDLE:
  - din_valid & din_sop: acc_j <= din for all j, cnt <= 1, go to ACC.
  - din_valid & !din_sop: symbol dropped, frame_err pulses next cycle.
- ACC:
  - din_valid & !din_sop: acc_j <= acc_j*alpha^(FCR+j) XOR din, cnt <= cnt+1.
  - din_valid & din_sop: current frame aborted, frame_err pulses, the frame restarts with this symbol (acc_j <= din, cnt <= 1). No synd_valid for the aborted frame.
  - din_valid=0: everything holds. Gaps of any length are allowed.

Completion:
- On the edge accepting the 255th symbol (cnt=254 & din_valid & !din_sop):
  - synd_j <= acc_j*alpha^(FCR+j) XOR din.
  - synd_nz <= OR of those values.
  - synd_valid = 1 for exactly the following cycle.
  - cnt <= 0, go to IDLE.
- Latency: synd_valid rises 1 cycle after the last symbol is accepted.

Back-to-back and output registers:
- A din_sop in the cycle immediately after the last symbol is accepted normally. Zero dead cycles are required, so full throughput is 1 symbol/clk.
- synd and synd_nz are registered and hold until the next completion or reset. They are not cleared when synd_valid drops.
- The accumulator multiply is combinational (one gf256_const_mult per syndrome) followed by the XOR. It must close timing in a single cycle with no extra pipeline.

Counter and error rules:
- cnt is 8 bits, range 0..254, and never wraps to 255.
- frame_err and synd_valid are never asserted in the same cycle for the same frame.
- Reset mid-frame discards the partial frame with no synd_valid.

Test Plan:
- Codeword of 255 zero symbols (sop on first), contiguous -> 1 cycle after last symbol: synd_valid=1, every S_j=0x00, synd_nz=0.
- Valid RS(255,239) codeword from the team encoder with random message, FCR=0 -> all S_j=0x00, synd_nz=0. Flip r_0 (last symbol) by XOR 0x05 -> every S_j=0x05, synd_nz=1.
- First symbol 0x01, remaining 254 symbols 0x00 (error at r_254), FCR=0 -> S_0=0x01, S_1=0x8E (alpha^-1), S_j=alpha^(-j) for all j.
- Same valid codeword with random din_valid gaps (1-10 idle cycles) -> results identical to the contiguous run; synd_valid pulses exactly once, 1 cycle after the 255th accepted symbol.
- Two codewords back-to-back with no idle cycle -> two synd_valid pulses 255 cycles apart, each with the correct syndromes. Then din_sop asserted at symbol 100 of a third frame -> frame_err pulse, the restarted frame completes correctly 255 accepted symbols later. Then din_valid without sop in IDLE -> frame_err, symbol ignored.
- Assert rst_n=0 at symbol 150 -> all outputs 0 immediately. The next frame after release yields correct syndromes with no stale contribution.

Source files
------------

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator over GF(2^8), poly 0x11D, alpha = 0x02.
// Horner accumulation of all NPAR syndromes in parallel, one symbol per clock.

module gf256_const_mult #(
  parameter logic [7:0] A = 8'h02
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_p
);

  // Shift-and-add multiply; with A constant this reduces to a fixed XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign o_p = gf_mul(i_a, A);

endmodule

module rs_syndrome_calc #(
  parameter int NPAR = 16,
  parameter int FCR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              din_sop,
  output logic [8*NPAR-1:0] synd,
  output logic              synd_valid,
  output logic              synd_nz,
  output logic              frame_err
);

  localparam int SW = 8 * NPAR;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < (e % 255); i++) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [SW-1:0]   r_acc;
  logic [SW-1:0]   w_acc_nxt;
  logic [SW-1:0]   w_mul;
  logic [SW-1:0]   w_step;
  logic            w_done;
  logic            w_ferr;
  logic [SW-1:0]   r_synd;
  logic            r_synd_valid;
  logic            r_synd_nz;
  logic            r_frame_err;

  generate
    for (genvar j = 0; j < NPAR; j++) begin : g_mul
      gf256_const_mult #(
        .A(gf_alpha_pow(FCR + j))
      ) u_mul (
        .i_a(r_acc[8*j +: 8]),
        .o_p(w_mul[8*j +: 8])
      );
    end
  endgenerate

  // One Horner step for every syndrome: acc_j * alpha^(FCR+j) + din.
  assign w_step = w_mul ^ {NPAR{din}};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (din_valid) begin
          if (din_sop) begin
            w_acc_nxt   = {NPAR{din}};
            w_cnt_nxt   = 8'd1;
            w_state_nxt = ACC;
          end else begin
            w_ferr = 1'b1;
          end
        end
      end
      ACC: begin
        if (din_valid) begin
          if (din_sop) begin
            // Abort the current frame and restart on this symbol.
            w_ferr    = 1'b1;
            w_acc_nxt = {NPAR{din}};
            w_cnt_nxt = 8'd1;
          end else if (r_cnt == 8'd254) begin
            w_done      = 1'b1;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = IDLE;
          end else begin
            w_acc_nxt = w_step;
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 8'd0;
      r_acc        <= '0;
      r_synd       <= '0;
      r_synd_valid <= 1'b0;
      r_synd_nz    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_acc        <= w_acc_nxt;
      r_synd_valid <= w_done;
      r_frame_err  <= w_ferr;
      if (w_done) begin
        r_synd    <= w_step;
        r_synd_nz <= |w_step;
      end
    end
  end

  assign synd       = r_synd;
  assign synd_valid = r_synd_valid;
  assign synd_nz    = r_synd_nz;
  assign frame_err  = r_frame_err;

endmodule
